// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (radix-2 shift-add and
// restoring divide on operand magnitudes, sign fix-up in a final cycle).
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, kill          request (accepted in IDLE only), synchronous abort
//   op                   RV32M funct3 (0 MUL .. 7 REMU)
//   operand1, operand2   rs1 / rs2 values, sampled with start
//   busy                 high while an operation is in flight
//   valid                one-cycle pulse when result is updated
//   result               registered result, held until the next operation
module muldiv_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            kill,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] operand1,
   input  logic [XLEN-1:0] operand2,
   output logic            busy,
   output logic            valid,
   output logic [XLEN-1:0] result
);

   localparam int unsigned CW = $clog2(XLEN);
   localparam int unsigned PW = 2 * XLEN;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t          state_q, state_d;
   logic [2:0]      op_q, op_d;
   logic            neg_q, neg_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] mag1_q, mag1_d;
   logic [XLEN-1:0] mag2_q, mag2_d;
   logic [PW-1:0]   acc_q, acc_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] result_d;
   logic            busy_d, valid_d;

   // Operand decode for the start cycle
   logic            signed1, signed2, s1, s2;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            div_zero, div_ovf;

   always_comb begin
      signed1  = ~(op[0] & (op[1] | op[2]));
      signed2  = signed1 & (op != 3'd2);
      s1       = operand1[XLEN-1] & signed1;
      s2       = operand2[XLEN-1] & signed2;
      a_mag    = s1 ? (~operand1 + XLEN'(1)) : operand1;
      b_mag    = s2 ? (~operand2 + XLEN'(1)) : operand2;
      div_zero = op[2] & (operand2 == '0);
      div_ovf  = op[2] & ~op[0] & (operand1 == MIN_NEG) & (&operand2);
   end

   // One iteration of shift-add multiply and restoring divide
   logic [XLEN:0]   msum, trial, diff;
   logic            fits;
   logic [PW-1:0]   acc_step;
   logic [XLEN-1:0] quo_step, rem_step;

   always_comb begin
      msum     = {1'b0, acc_q[PW-1:XLEN]} + (acc_q[0] ? {1'b0, mag1_q} : '0);
      acc_step = {msum, acc_q[XLEN-1:1]};
      trial    = {rem_q, quo_q[XLEN-1]};
      diff     = trial - {1'b0, mag2_q};
      fits     = ~diff[XLEN];
      rem_step = fits ? diff[XLEN-1:0] : trial[XLEN-1:0];
      quo_step = {quo_q[XLEN-2:0], fits};
   end

   // Sign fix-up and result select
   logic [PW-1:0]   prod_fix;
   logic [XLEN-1:0] quo_fix, rem_fix, sel_fix;

   always_comb begin
      prod_fix = neg_q ? (~acc_q + PW'(1)) : acc_q;
      quo_fix  = neg_q ? (~quo_q + XLEN'(1)) : quo_q;
      rem_fix  = neg_q ? (~rem_q + XLEN'(1)) : rem_q;
      if (op_q[2])           sel_fix = op_q[1] ? rem_fix : quo_fix;
      else if (op_q[1:0] == 2'd0) sel_fix = prod_fix[XLEN-1:0];
      else                   sel_fix = prod_fix[PW-1:XLEN];
   end

   // Next-state and datapath update
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      neg_d    = neg_q;
      cnt_d    = cnt_q;
      mag1_d   = mag1_q;
      mag2_d   = mag2_q;
      acc_d    = acc_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      result_d = result;

      case (state_q)
         IDLE: begin
            if (start) begin
               op_d = op;
               if (div_zero) begin
                  result_d = op[1] ? operand1 : '1;
                  state_d  = DONE;
               end else if (div_ovf) begin
                  result_d = op[1] ? '0 : operand1;
                  state_d  = DONE;
               end else begin
                  neg_d   = (op[2] & op[1]) ? s1 : (s1 ^ s2);
                  mag1_d  = a_mag;
                  mag2_d  = b_mag;
                  acc_d   = {{XLEN{1'b0}}, b_mag};
                  quo_d   = a_mag;
                  rem_d   = '0;
                  cnt_d   = '0;
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            if (op_q[2]) begin
               quo_d = quo_step;
               rem_d = rem_step;
            end else begin
               acc_d = acc_step;
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(XLEN - 1)) state_d = FIX;
         end
         FIX: begin
            result_d = sel_fix;
            state_d  = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Flush overrides everything, including a start in IDLE
      if (kill) begin
         state_d  = IDLE;
         result_d = result;
      end

      busy_d  = (state_d != IDLE);
      valid_d = (state_d == DONE);
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         neg_q   <= 1'b0;
         cnt_q   <= '0;
         mag1_q  <= '0;
         mag2_q  <= '0;
         acc_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         result  <= '0;
         busy    <= 1'b0;
         valid   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         neg_q   <= neg_d;
         cnt_q   <= cnt_d;
         mag1_q  <= mag1_d;
         mag2_q  <= mag2_d;
         acc_q   <= acc_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         result  <= result_d;
         busy    <= busy_d;
         valid   <= valid_d;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, abort/ignored-start,
// mid-operation reset and random operations against a behavioural model.
module tb_muldiv_unit;

   localparam int unsigned XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start;
   logic            kill;
   logic [2:0]      op;
   logic [XLEN-1:0] operand1;
   logic [XLEN-1:0] operand2;
   logic            busy;
   logic            valid;
   logic [XLEN-1:0] result;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] sb_q[$];

   muldiv_unit #(.XLEN(XLEN)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .kill     (kill),
      .op       (op),
      .operand1 (operand1),
      .operand2 (operand2),
      .busy     (busy),
      .valid    (valid),
      .result   (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Behavioural RV32M reference
   function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, sp;
      logic [63:0] up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (f)
         3'd0: begin sp = sa * sb; return sp[31:0]; end
         3'd1: begin sp = sa * sb; return sp[63:32]; end
         3'd2: begin sp = sa * longint'({32'd0, b}); return sp[63:32]; end
         3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            sp = sa / sb; return sp[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            sp = sa % sb; return sp[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (!f[2]) return 1'b0;
      if (b == 0) return 1'b1;
      return !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
   endfunction

   // Scoreboard: every valid pops one expected result
   always @(negedge clk) begin
      if (rst_n && valid) begin
         if (sb_q.size() == 0) check("unexpected_valid", 64'(valid), 64'd0);
         else check("result", 64'(result), 64'(sb_q.pop_front()));
      end
   end

   // Issue one operation and wait (bounded) for its valid; optionally poke a
   // start while busy, which must be ignored.
   task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit poke);
      int lat;
      int busy_cyc;
      int exp_lat;
      exp_lat  = is_special(f, a, b) ? 1 : XLEN + 2;
      op       = f;
      operand1 = a;
      operand2 = b;
      start    = 1'b1;
      sb_q.push_back(exp);
      lat      = 0;
      busy_cyc = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
         start = poke && (lat == 5);
         if (start) begin
            op       = 3'd0;
            operand1 = 32'd3;
            operand2 = 32'd4;
         end
         if (busy) busy_cyc++;
      end while (!valid && lat < 100);
      start = 1'b0;
      check("latency", 64'(lat), 64'(exp_lat));
      check("busy_cycles", 64'(busy_cyc), 64'(exp_lat));
      @(posedge clk);
      #1;
      check("busy_after", 64'(busy), 64'd0);
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   logic [2:0]  rf;
   logic [31:0] ra, rb;

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      kill     = 1'b0;
      op       = 3'd0;
      operand1 = '0;
      operand2 = '0;
      #12;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_valid", 64'(valid), 64'd0);
      check("reset_result", 64'(result), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycles(1);

      // Directed vectors
      do_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
      do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
      do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
      do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      do_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0);
      do_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0);
      do_op(3'd5, 32'd100, 32'd7, 32'h0000_000E, 1'b0);
      do_op(3'd7, 32'd100, 32'd7, 32'h0000_0002, 1'b0);
      do_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
      do_op(3'd7, 32'd5, 32'd0, 32'h0000_0005, 1'b0);
      do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
      do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);

      // Start while busy is ignored: DIVU still completes normally
      do_op(3'd5, 32'd100, 32'd7, 32'h0000_000E, 1'b1);

      // Kill at cycle 10 of a DIV
      op       = 3'd4;
      operand1 = 32'd1000;
      operand2 = 32'd3;
      start    = 1'b1;
      cycles(1);
      start = 1'b0;
      cycles(9);
      check("kill_busy_before", 64'(busy), 64'd1);
      kill = 1'b1;
      cycles(1);
      kill = 1'b0;
      check("kill_busy", 64'(busy), 64'd0);
      check("kill_result", 64'(result), 64'h0000_000E);
      cycles(40);
      check("kill_valid", 64'(valid), 64'd0);

      // Kill and start together in IDLE: start dropped
      op       = 3'd0;
      operand1 = 32'd9;
      operand2 = 32'd9;
      start    = 1'b1;
      kill     = 1'b1;
      cycles(1);
      start = 1'b0;
      kill  = 1'b0;
      check("kill_start_busy", 64'(busy), 64'd0);
      cycles(3);

      do_op(3'd0, 32'd3, 32'd4, 32'h0000_000C, 1'b0);

      // Asynchronous reset mid-CALC
      op       = 3'd4;
      operand1 = 32'd1000;
      operand2 = 32'd3;
      start    = 1'b1;
      cycles(1);
      start = 1'b0;
      cycles(10);
      rst_n = 1'b0;
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_valid", 64'(valid), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycles(1);
      do_op(3'd4, 32'h0000_0064, 32'h0000_000A, 32'h0000_000A, 1'b0);

      // Random operations against the model
      for (int i = 0; i < 24; i++) begin
         rf = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 9) == 0) begin
            ra = 32'h8000_0000;
            rb = 32'hFFFF_FFFF;
         end
         do_op(rf, ra, rb, ref_op(rf, ra, rb), 1'b0);
      end

      cycles(2);
      check("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
